// File: rtl/lcd_pkg.sv
// Shared types and ASCII constants for the LCD field streamer and its BCD converter.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_NAME,
    ST_SEP,
    ST_WAIT_BCD,
    ST_DIGITS
  } state_t;

  localparam logic [7:0] ASC_ZERO     = 8'h30;
  localparam logic [7:0] ASC_SPACE    = 8'h20;
  localparam logic [7:0] ASC_QMARK    = 8'h3F;
  localparam logic [7:0] ASC_NINE     = 8'h39;
  localparam logic [7:0] ASC_PRINT_LO = 8'h20;
  localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

endpackage

// File: rtl/lcd_field_streamer_if.sv
// Ready/valid character link between the field streamer (master) and the LCD writer (slave).
interface lcd_field_streamer_if;
  logic [7:0] ascii_data;
  logic       lcd_we;
  logic       lcd_reset;
  logic       lcd_ready;

  modport master (output ascii_data, output lcd_we, output lcd_reset, input lcd_ready);
  modport slave  (input ascii_data, input lcd_we, input lcd_reset, output lcd_ready);
endinterface

// File: rtl/lcd_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, done after SCORE_W shifts.
module lcd_bin2bcd #(
  parameter int SCORE_W      = 8,
  parameter int SCORE_DIGITS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SCORE_W-1:0]        bin,
  output logic                      done,
  output logic [4*SCORE_DIGITS-1:0] digits,
  output logic                      overflow
);

  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Internal digit count covers the full binary range even when fewer digits are shown.
  localparam int BCD_N = (dec_digits(SCORE_W) > SCORE_DIGITS) ? dec_digits(SCORE_W) : SCORE_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam longint unsigned LIMIT = pow10(SCORE_DIGITS);

  logic [4*BCD_N-1:0] bcd, adj;
  logic [SCORE_W-1:0] sh;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_N; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      cnt  <= CNT_W'(SCORE_W);
      done <= 1'b0;
    end else if (cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
      done <= (cnt == CNT_W'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      sh       <= bin;
      bcd      <= '0;
      overflow <= ({{(64-SCORE_W){1'b0}}, bin} >= LIMIT);
    end else if (cnt != '0) begin
      {bcd, sh} <= {adj, sh} << 1;
    end
  end

  assign digits = bcd[4*SCORE_DIGITS-1:0];

endmodule

// File: rtl/lcd_field_streamer.sv
// Streams clear + name + separator + decimal score to an LCD writer whenever name or score changes.
// Optional: LCD_BLANK_LEADING_ZERO_EN sends leading zero digits (except the last) as spaces.
module lcd_field_streamer
  import lcd_pkg::*;
#(
  parameter int         NAME_CHARS   = 2,
  parameter int         SCORE_W      = 8,
  parameter int         SCORE_DIGITS = 3,
  parameter logic [7:0] SEP_CHAR     = 8'h3A
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [8*NAME_CHARS-1:0] name,
  input  logic [SCORE_W-1:0]      score,
  lcd_field_streamer_if.master    lcd,
  output logic                    busy
);

  localparam int IDX_MAX = (NAME_CHARS > SCORE_DIGITS) ? NAME_CHARS : SCORE_DIGITS;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  function automatic logic [7:0] sanitize(input logic [7:0] b);
    return (b < ASC_PRINT_LO || b > ASC_PRINT_HI) ? ASC_QMARK : b;
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] d, input logic ovf);
    return ovf ? ASC_NINE : (ASC_ZERO + {4'h0, d});
  endfunction

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic [8*NAME_CHARS-1:0] old_name;
  logic [SCORE_W-1:0]      old_score;
  logic                    conv_start, bcd_done, bcd_ovf;
  logic [4*SCORE_DIGITS-1:0] bcd_digits;
  logic [7:0]              name_ch;
  logic [3:0]              dsel;
  logic                    changed;

  lcd_bin2bcd #(.SCORE_W(SCORE_W), .SCORE_DIGITS(SCORE_DIGITS)) u_bin2bcd (
    .clock    (clock),
    .reset    (reset),
    .start    (conv_start),
    .bin      (score),
    .done     (bcd_done),
    .digits   (bcd_digits),
    .overflow (bcd_ovf)
  );

  assign changed = (name != old_name) || (score != old_score);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      old_name  <= '0;
      old_score <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (conv_start) begin
        old_name  <= name;
        old_score <= score;
      end
    end
  end

  always_comb begin
    name_ch = '0;
    for (int i = 0; i < NAME_CHARS; i++)
      if (idx == IDX_W'(i)) name_ch = old_name[8*(NAME_CHARS-1-i) +: 8];
  end

`ifdef LCD_BLANK_LEADING_ZERO_EN
  logic lead_blank;
`endif

  // dsel is the digit at idx (MS first); lead_blank means every digit up to idx is zero.
  always_comb begin
    dsel = '0;
`ifdef LCD_BLANK_LEADING_ZERO_EN
    lead_blank = (idx != IDX_W'(SCORE_DIGITS-1));
`endif
    for (int k = 0; k < SCORE_DIGITS; k++) begin
      if (idx == IDX_W'(k)) dsel = bcd_digits[4*(SCORE_DIGITS-1-k) +: 4];
`ifdef LCD_BLANK_LEADING_ZERO_EN
      if (IDX_W'(k) <= idx && bcd_digits[4*(SCORE_DIGITS-1-k) +: 4] != 4'd0) lead_blank = 1'b0;
`endif
    end
  end

  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    conv_start     = 1'b0;
    lcd.lcd_we     = 1'b0;
    lcd.lcd_reset  = 1'b0;
    lcd.ascii_data = '0;
    case (state)
      ST_IDLE: begin
        if (changed) begin
          conv_start = 1'b1;
          state_nx   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        lcd.lcd_reset = 1'b1;
        idx_nx        = '0;
        state_nx      = ST_NAME;
      end
      ST_NAME: begin
        lcd.lcd_we     = 1'b1;
        lcd.ascii_data = sanitize(name_ch);
        if (lcd.lcd_ready) begin
          if (idx == IDX_W'(NAME_CHARS-1)) begin
            idx_nx   = '0;
            state_nx = ST_SEP;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end
      ST_SEP: begin
        lcd.lcd_we     = 1'b1;
        lcd.ascii_data = SEP_CHAR;
        // Skip the wait state entirely when the converter already finished.
        if (lcd.lcd_ready) state_nx = bcd_done ? ST_DIGITS : ST_WAIT_BCD;
      end
      ST_WAIT_BCD: begin
        if (bcd_done) state_nx = ST_DIGITS;
      end
      ST_DIGITS: begin
        lcd.lcd_we     = 1'b1;
        lcd.ascii_data = digit_ascii(dsel, bcd_ovf);
`ifdef LCD_BLANK_LEADING_ZERO_EN
        if (lead_blank && !bcd_ovf) lcd.ascii_data = ASC_SPACE;
`endif
        if (lcd.lcd_ready) begin
          if (idx == IDX_W'(SCORE_DIGITS-1)) begin
            idx_nx   = '0;
            state_nx = ST_IDLE;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_field_streamer.sv
// Scoreboard bench for lcd_field_streamer: default instance plus a SCORE_W=10 instance.
module tb_lcd_field_streamer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [15:0] name0, name1;
  logic [7:0]  score0;
  logic [9:0]  score1;
  logic        busy0, busy1;

  lcd_field_streamer_if f0();
  lcd_field_streamer_if f1();

  lcd_field_streamer dut0 (
    .clock (clock), .reset (reset), .name (name0), .score (score0), .lcd (f0), .busy (busy0)
  );

  lcd_field_streamer #(.SCORE_W(10), .SCORE_DIGITS(3)) dut1 (
    .clock (clock), .reset (reset), .name (name1), .score (score1), .lcd (f1), .busy (busy1)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       st0 = 1'b0, st1 = 1'b0;
  logic [7:0] pd0 = '0, pd1 = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned pow10(input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [8:0] pop0();
    if (q0.size() == 0) return 9'h1FF;
    return q0.pop_front();
  endfunction

  function automatic logic [8:0] pop1();
    if (q1.size() == 0) return 9'h1FF;
    return q1.pop_front();
  endfunction

  task automatic push_exp(input int d, input logic [8:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // Expected stream: clear token (bit 8), name chars, ':', then decimal digits.
  task automatic push_refresh(input int d, input logic [15:0] nm, input int unsigned sc, input int digs);
    logic [7:0] b;
    int unsigned p;
    push_exp(d, 9'h100);
    for (int i = 0; i < 2; i++) begin
      b = nm[15-8*i -: 8];
      if (b < 8'h20 || b > 8'h7E) b = 8'h3F;
      push_exp(d, {1'b0, b});
    end
    push_exp(d, 9'h03A);
    for (int i = 0; i < digs; i++) begin
      p = pow10(digs-1-i);
      if (sc >= pow10(digs)) b = 8'h39;
      else b = 8'h30 + 8'((sc / p) % 10);
`ifdef LCD_BLANK_LEADING_ZERO_EN
      if (sc < pow10(digs) && (sc / p) == 0 && i != digs-1) b = 8'h20;
`endif
      push_exp(d, {1'b0, b});
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (!f0.lcd_we) check_val("d0_idle_data", f0.ascii_data, 0);
      if (f0.lcd_reset) check_val("d0_clear", {f0.lcd_reset, f0.ascii_data}, pop0());
      if (st0 && f0.lcd_we) check_val("d0_stall_hold", f0.ascii_data, pd0);
      if (f0.lcd_we && f0.lcd_ready) check_val("d0_char", {1'b0, f0.ascii_data}, pop0());
    end
    st0 <= !reset && f0.lcd_we && !f0.lcd_ready;
    pd0 <= f0.ascii_data;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (!f1.lcd_we) check_val("d1_idle_data", f1.ascii_data, 0);
      if (f1.lcd_reset) check_val("d1_clear", {f1.lcd_reset, f1.ascii_data}, pop1());
      if (st1 && f1.lcd_we) check_val("d1_stall_hold", f1.ascii_data, pd1);
      if (f1.lcd_we && f1.lcd_ready) check_val("d1_char", {1'b0, f1.ascii_data}, pop1());
    end
    st1 <= !reset && f1.lcd_we && !f1.lcd_ready;
    pd1 <= f1.ascii_data;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int d, input int budget, input bit toggle);
    int n = 0;
    while (n < budget && (d == 0 ? (q0.size() != 0 || busy0) : (q1.size() != 0 || busy1))) begin
      tick();
      if (toggle) f0.lcd_ready = (n % 3 == 0);
      n++;
    end
    if (d == 0) begin
      check_val("d0_drain_q", q0.size(), 0);
      check_val("d0_drain_busy", busy0, 0);
    end else begin
      check_val("d1_drain_q", q1.size(), 0);
      check_val("d1_drain_busy", busy1, 0);
    end
  endtask

  task automatic wait_char0(input logic [7:0] c, input int budget);
    int n = 0;
    while (!(f0.lcd_we && f0.ascii_data == c) && n < budget) begin
      tick();
      n++;
    end
    check_val("d0_wait_char", f0.ascii_data, c);
  endtask

  initial begin
    name0 = '0; score0 = '0; name1 = '0; score1 = '0;
    f0.lcd_ready = 1'b1;
    f1.lcd_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_we", f0.lcd_we, 0);
    check_val("rst_clr", f0.lcd_reset, 0);
    check_val("rst_data", f0.ascii_data, 0);
    check_val("rst_busy0", busy0, 0);
    check_val("rst_busy1", busy1, 0);
    reset = 1'b0;
    repeat (4) tick();
    check_val("zero_inputs_idle", busy0, 0);

    // Basic refresh with ready held high, including first-cycle latency.
    name0 = 16'h4E47; score0 = 8'd42;
    push_refresh(0, name0, 42, 3);
    tick();
    check_val("t1_clr_cycle", f0.lcd_reset, 1);
    tick();
    check_val("t1_first_char", {f0.lcd_we, f0.ascii_data}, {1'b1, 8'h4E});
    drain(0, 100, 1'b0);

    // Ready toggling 1,0,0,...
    score0 = 8'd200;
    push_refresh(0, name0, 200, 3);
    drain(0, 300, 1'b1);
    f0.lcd_ready = 1'b1;

    // Score change while 'G' is stalled: two refreshes back to back.
    f0.lcd_ready = 1'b0;
    score0 = 8'd42;
    push_refresh(0, name0, 42, 3);
    wait_char0(8'h4E, 20);
    f0.lcd_ready = 1'b1;
    tick();
    f0.lcd_ready = 1'b0;
    check_val("t3_g_stalled", f0.ascii_data, 8'h47);
    score0 = 8'd7;
    push_refresh(0, name0, 7, 3);
    repeat (3) tick();
    f0.lcd_ready = 1'b1;
    drain(0, 200, 1'b0);

    // Wide score instance: overflow, exact max, small values, unprintable name byte.
    name1 = 16'h0A41; score1 = 10'd1023;
    push_refresh(1, name1, 1023, 3);
    drain(1, 100, 1'b0);
    score1 = 10'd999;
    push_refresh(1, name1, 999, 3);
    drain(1, 100, 1'b0);
    score1 = 10'd5;
    push_refresh(1, name1, 5, 3);
    drain(1, 100, 1'b0);
    score1 = 10'd0;
    push_refresh(1, name1, 0, 3);
    drain(1, 100, 1'b0);

    // Reset while the separator is presented and stalled.
    score0 = 8'd99;
    push_refresh(0, name0, 99, 3);
    wait_char0(8'h3A, 30);
    f0.lcd_ready = 1'b0;
    reset = 1'b1;
    tick();
    check_val("abort_we", f0.lcd_we, 0);
    check_val("abort_clr", f0.lcd_reset, 0);
    check_val("abort_data", f0.ascii_data, 0);
    check_val("abort_busy", busy0, 0);
    q0.delete();
    q1.delete();
    push_refresh(0, name0, 99, 3);
    push_refresh(1, name1, 0, 3);
    reset = 1'b0;
    f0.lcd_ready = 1'b1;
    drain(0, 100, 1'b0);
    drain(1, 100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
